// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: opcodes, FSM states and flag bit positions.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_LSL = 3'b101,
    OP_LSR = 3'b110,
    OP_MUL = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [1:0] FLAG_N = 2'd3;
  localparam logic [1:0] FLAG_Z = 2'd2;
  localparam logic [1:0] FLAG_C = 2'd1;
  localparam logic [1:0] FLAG_V = 2'd0;

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bundle of the sequential ALU: operand handshake in, result handshake out.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, flags
  );
endinterface

// File: rtl/alu_addsub.sv
// WIDTH-bit adder/subtractor (sub: x + ~y + 1) with carry-out and signed overflow.
module alu_addsub #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);
  logic [WIDTH-1:0] y_eff;

  always_comb begin
    y_eff           = sub ? ~y : y;
    {carry, sum}    = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, sub};
    overflow        = (x[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
  end
endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops, WIDTH-cycle shift-add multiply,
// registered result and {N,Z,C,V} flags held until the consumer accepts them.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input logic          clk,
  input logic          reset_n,
  seq_alu_if.slave     bus
);
  localparam logic [SHW-1:0] LAST_BIT = SHW'(WIDTH - 1);

  state_t           state, state_next;
  op_t              op;
  logic             transfer, is_mul, ready, valid;
  logic [WIDTH-1:0] acc, mcand, mplier, result_q;
  logic [SHW-1:0]   cnt;
  logic [3:0]       flags_q, alu_flags, mul_flags;
  logic [WIDTH-1:0] add_x, add_y, sum, alu_res, mul_next;
  logic             add_sub, carry, overflow;

  assign op       = op_t'(bus.op);
  assign is_mul   = (op == OP_MUL);
  assign transfer = bus.in_valid && ready;

  // The adder serves the single-cycle ops when not BUSY and the MUL accumulator while BUSY.
  always_comb begin
    add_x   = (state == BUSY) ? acc   : bus.a;
    add_y   = (state == BUSY) ? mcand : bus.b;
    add_sub = (state != BUSY) && (op == OP_SUB);
  end

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .x        (add_x),
    .y        (add_y),
    .sub      (add_sub),
    .sum      (sum),
    .carry    (carry),
    .overflow (overflow)
  );

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD, OP_SUB: alu_res = sum;
      OP_AND:         alu_res = bus.a & bus.b;
      OP_OR:          alu_res = bus.a | bus.b;
      OP_XOR:         alu_res = bus.a ^ bus.b;
      OP_LSL:         alu_res = bus.a << bus.b[SHW-1:0];
      OP_LSR:         alu_res = bus.a >> bus.b[SHW-1:0];
      default:        alu_res = '0;
    endcase
    alu_flags         = '0;
    alu_flags[FLAG_N] = alu_res[WIDTH-1];
    alu_flags[FLAG_Z] = (alu_res == '0);
    alu_flags[FLAG_C] = ((op == OP_ADD) || (op == OP_SUB)) && carry;
    alu_flags[FLAG_V] = ((op == OP_ADD) || (op == OP_SUB)) && overflow;

    mul_next          = mplier[0] ? sum : acc;
    mul_flags         = '0;
    mul_flags[FLAG_N] = mul_next[WIDTH-1];
    mul_flags[FLAG_Z] = (mul_next == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (transfer) state_next = is_mul ? BUSY : DONE;
      BUSY: if (cnt == LAST_BIT) state_next = DONE;
      DONE: if (bus.out_ready) state_next = transfer ? (is_mul ? BUSY : DONE) : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE) || ((state == DONE) && bus.out_ready);
    valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_q <= '0;
      flags_q  <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
    end else if (transfer) begin
      if (is_mul) begin
        acc    <= '0;
        mcand  <= bus.a;
        mplier <= bus.b;
        cnt    <= '0;
      end else begin
        result_q <= alu_res;
        flags_q  <= alu_flags;
      end
    end else if (state == BUSY) begin
      acc    <= mul_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + SHW'(1);
      if (cnt == LAST_BIT) begin
        result_q <= mul_next;
        flags_q  <= mul_flags;
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed + randomized bench for seq_alu (WIDTH=32) against an arithmetic reference model.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {N,Z,C,V, result} from plain integer arithmetic.
  function automatic logic [35:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint unsigned ux, uy, p;
    longint          sx, sy, s;
    logic [31:0]     r;
    logic            c, v;
    ux = 64'(x);
    uy = 64'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = '0; c = 1'b0; v = 1'b0; p = 0; s = 0;
    case (o)
      3'd0: begin p = ux + uy; r = p[31:0]; c = (p > 64'hFFFF_FFFF);
              s = sx + sy; v = (s != longint'($signed(r))); end
      3'd1: begin r = x - y; c = (x >= y);
              s = sx - sy; v = (s != longint'($signed(r))); end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = x << y[4:0];
      3'd6: r = x >> y[4:0];
      default: begin p = ux * uy; r = p[31:0]; end
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int hold, output logic [31:0] res, output logic [3:0] flg);
    logic [35:0] exp;
    int          lat;
    exp = model(o, x, y);
    @(negedge clk);
    check("in_ready_idle", bus.in_ready, 1);
    bus.op = o; bus.a = x; bus.b = y; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    // Junk request stays asserted while the block is busy/holding; it must be ignored.
    bus.op = 3'd0; bus.a = $urandom; bus.b = $urandom;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      if (lat == 1 && o == OP_MUL) check("in_ready_busy", bus.in_ready, 0);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, (o == OP_MUL) ? 33 : 1);
    repeat (hold) @(negedge clk);
    bus.in_valid = 1'b0;
    res = bus.result;
    flg = bus.flags;
    check("out_valid_hold", bus.out_valid, 1);
    check("result", res, exp[31:0]);
    check("flags", flg, exp[35:32]);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("out_valid_retired", bus.out_valid, 0);
  endtask

  initial begin
    logic [31:0] res, x, y;
    logic [3:0]  flg;
    logic [35:0] exp;
    logic [2:0]  o;
    int          seen;

    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0;
    reset_n = 1'b0;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result, 0);
    check("rst_flags", bus.flags, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", bus.in_ready, 1);

    run_op(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0, res, flg);
    check("add_ovf_res", res, 32'h8000_0000);
    check("add_ovf_flags", flg, 4'b1001);
    run_op(OP_SUB, 32'd5, 32'd5, 1, res, flg);
    check("sub_eq_res", res, 32'd0);
    check("sub_eq_flags", flg, 4'b0110);
    run_op(OP_SUB, 32'd3, 32'd5, 0, res, flg);
    check("sub_neg_res", res, 32'hFFFF_FFFE);
    check("sub_neg_flags", flg, 4'b1000);
    run_op(OP_MUL, 32'h0001_0000, 32'h0001_0000, 0, res, flg);
    check("mul_wrap_res", res, 32'd0);
    check("mul_wrap_flags", flg, 4'b0100);
    run_op(OP_MUL, 32'd7, 32'd6, 2, res, flg);
    check("mul_small_res", res, 32'd42);
    check("mul_small_flags", flg, 4'b0000);
    run_op(OP_LSR, 32'h8000_0000, 32'h0000_003F, 0, res, flg);
    check("lsr31_res", res, 32'h0000_0001);
    check("lsr31_flags", flg, 4'b0000);
    run_op(OP_LSL, 32'hDEAD_BEEF, 32'h0000_0020, 0, res, flg);
    check("lsl0_res", res, 32'hDEAD_BEEF);

    // Backpressure hold followed by a back-to-back transfer on the releasing cycle.
    @(negedge clk);
    bus.op = OP_AND; bus.a = 32'hF0F0_F0F0; bus.b = 32'hFF00_FF00; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", bus.out_valid, 1);
      check("hold_result", bus.result, 32'hF000_F000);
      check("hold_flags", bus.flags, 4'b1000);
      check("hold_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    x = 32'h1234_0000; y = 32'h0000_5678;
    bus.op = OP_OR; bus.a = x; bus.b = y; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1;
    check("b2b_in_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    exp = model(OP_OR, x, y);
    check("b2b_valid", bus.out_valid, 1);
    check("b2b_result", bus.result, exp[31:0]);
    check("b2b_flags", bus.flags, exp[35:32]);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Reset in the middle of a multiply.
    bus.op = OP_MUL; bus.a = 32'h0000_1234; bus.b = 32'h0000_5678; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_result", bus.result, 0);
    check("abort_flags", bus.flags, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    bus.out_ready = 1'b0;
    check("abort_no_stale", seen, 0);

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      if (i % 4 == 0) y = 32'($urandom_range(0, 255));
      run_op(o, x, y, $urandom_range(0, 3), res, flg);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (>= 8, power of 2).
REQ-002 Parameter: SHW, default $clog2(WIDTH), shift-amount bits taken from b.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operands/op presented.
REQ-006 in_ready  output  1  block can accept an operation this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B (low SHW bits = shift amount for shifts).
REQ-009 op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 LSL, 110 LSR, 111 MUL.
REQ-010 out_valid  output  1  result/flags valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WIDTH  registered result.
REQ-013 flags  output  4  registered {N,Z,C,V}.

Function
REQ-014 A transfer SHALL occur on a cycle with in_valid && in_ready; a, b and op are captured on that edge.
REQ-015 The FSM SHALL have states IDLE, BUSY, DONE; reset state is IDLE.
REQ-016 IDLE -> DONE on transfer of any non-MUL op; IDLE -> BUSY on transfer of MUL.
REQ-017 Non-MUL ops SHALL have out_valid high the cycle after transfer (latency 1).
REQ-018 MUL SHALL be computed by shift-add, one multiplier bit per cycle, BUSY lasting exactly WIDTH cycles, out_valid high WIDTH+1 cycles after transfer.
REQ-019 MUL result SHALL be the low WIDTH bits of the unsigned product.
REQ-020 in_ready SHALL be (state==IDLE) || (state==DONE && out_ready).
REQ-021 In DONE, result, flags and out_valid SHALL hold stable until out_ready is high.
REQ-022 DONE with out_ready and no transfer SHALL go to IDLE; DONE with out_ready and simultaneous transfer SHALL go to DONE (non-MUL) or BUSY (MUL), with no idle bubble.
REQ-023 in_valid during BUSY SHALL be ignored (in_ready low).
REQ-024 ADD/SUB SHALL be WIDTH-bit two's complement; SUB = a + ~b + 1.
REQ-025 N = result[WIDTH-1]; Z = (result == 0) for all ops.
REQ-026 C = carry-out for ADD, carry-out of a + ~b + 1 (1 = no borrow) for SUB; 0 for all other ops.
REQ-027 V = signed overflow for ADD/SUB; 0 for all other ops.
REQ-028 LSL/LSR SHALL be logical, amount = b[SHW-1:0]; amount 0 returns a unchanged.
REQ-029 out_valid SHALL be high only in DONE.

Reset
REQ-030 reset_n low SHALL immediately force state IDLE, out_valid 0, result 0, flags 0, MUL accumulator/counter 0.
REQ-031 in_ready SHALL be 1 from the first clock edge after reset_n rises.
REQ-032 Reset during BUSY SHALL abort the MUL; no result is ever presented for it.

Structure
REQ-033 Package alu_pkg SHALL hold the op encoding enum, the FSM state enum, and flag bit-index constants (N=3, Z=2, C=1, V=0).
REQ-034 The add/sub datapath with carry/overflow SHALL be one sub-module, alu_addsub, parametrised by WIDTH; the MUL accumulator reuses it.

Verification (WIDTH=32)
REQ-035 ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, flags 1001, out_valid one cycle after transfer.
REQ-036 SUB 5 - 5 -> result 0, flags 0110; SUB 3 - 5 -> 0xFFFFFFFE, flags 1000.
REQ-037 MUL 0x00010000 * 0x00010000 -> result 0, flags 0100, out_valid exactly 33 cycles after transfer; MUL 7 * 6 -> 42, flags 0000.
REQ-038 LSR a=0x80000000, b=0x0000003F -> result 0x00000001 (amount 31), flags 0000.
REQ-039 Hold out_ready low 5 cycles after an AND 0xF0F0F0F0 & 0xFF00FF00 -> result 0xF000F000 and flags 1000 stable, in_ready 0; raise out_ready with in_valid (OR) -> transfer same cycle, next result the following cycle.
REQ-040 Drop reset_n 10 cycles into a MUL -> out_valid, result, flags 0 immediately; in_ready 1 after release; no stale result appears.
